dot_matrix_scan: RTL and testbench

DOT_MATRIX_SCAN -- requirements
Module: dot_matrix_scan

---
 rtl/dot_matrix_scan_pkg.sv | 17 +
 rtl/dot_matrix_font.sv | 40 ++++
 rtl/dot_matrix_scan.sv | 134 +++++++++++++
 tb/tb_dot_matrix_scan.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_matrix_scan_pkg.sv
// Purpose: glyph index constants and the scan FSM state type shared by the display scan block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dot_matrix_scan_pkg;

  localparam logic [3:0] GLYPH_Q     = 4'd10;
  localparam logic [3:0] GLYPH_A     = 4'd11;
  localparam logic [3:0] GLYPH_GOOD  = 4'd12;
  localparam logic [3:0] GLYPH_BAD   = 4'd13;
  localparam logic [3:0] GLYPH_BLANK = 4'd14;

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/dot_matrix_font.sv
// Purpose: 8x8 font ROM; returns one pixel row of a glyph (bit 7 = leftmost column).
// Latency: combinational.
// Backpressure: none.
// Ports: glyph[3:0] glyph index, row[2:0] pixel row (0 = top), bits[7:0] active-high pixels.
module dot_matrix_font
  import dot_matrix_scan_pkg::*;
(
  input  logic [3:0] glyph,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  // Whole glyph as 8 bytes, top row in the most significant byte.
  logic [63:0] glyph_bits;

  always_comb begin
    glyph_bits = 64'h0;
    case (glyph)
      4'd0:       glyph_bits = 64'h3C666E7666663C00;
      4'd1:       glyph_bits = 64'h183818181818_7E00;
      4'd2:       glyph_bits = 64'h3C66060C30607E00;
      4'd3:       glyph_bits = 64'h3C66061C06663C00;
      4'd4:       glyph_bits = 64'h0C1C3C6C7E0C0C00;
      4'd5:       glyph_bits = 64'h7E607C0606663C00;
      4'd6:       glyph_bits = 64'h3C607C6666663C00;
      4'd7:       glyph_bits = 64'h7E060C1830303000;
      4'd8:       glyph_bits = 64'h3C66663C66663C00;
      4'd9:       glyph_bits = 64'h3C66663E060C3800;
      GLYPH_Q:    glyph_bits = 64'h00003E66663E0606;
      GLYPH_A:    glyph_bits = 64'h00003C063E663E00;
      GLYPH_GOOD: glyph_bits = 64'h000103068CD87020;
      GLYPH_BAD:  glyph_bits = 64'hC3663C18183C66C3;
      default:    glyph_bits = 64'h0;
    endcase
  end

  // ~row == 7-row for a 3-bit row, so row 0 selects bits [63:56].
  assign bits = glyph_bits[{~row, 3'b000} +: 8];

endmodule

// File: rtl/dot_matrix_scan.sv
// Purpose: multiplexed row scanner for N_PANEL 8x8 LED panels with double-buffered glyphs and blink.
// Latency: all outputs registered; the row processed on an edge appears one clk_div after it.
// Backpressure: load_ready is low while a shadow load awaits commit at the frame boundary.
// Ports: clk_div scan clock; reset async active-low; glyph_in/load_valid/load_ready glyph load
//        handshake; blink_en per-panel blink; blank forces dark; dot_row active-low row select;
//        dot_col active-high columns (panel p in [8p+7:8p]); frame_start pulses with row 0.
module dot_matrix_scan
  import dot_matrix_scan_pkg::*;
#(
  parameter int N_PANEL      = 2,
  parameter int ROWS         = 8,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                   clk_div,
  input  logic                   reset,
  input  logic [N_PANEL*4-1:0]   glyph_in,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [N_PANEL-1:0]     blink_en,
  input  logic                   blank,
  output logic [ROWS-1:0]        dot_row,
  output logic [N_PANEL*8-1:0]   dot_col,
  output logic                   frame_start
);

  localparam int                    FC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [2:0]            LAST_ROW   = 3'(ROWS - 1);
  localparam logic [FC_W-1:0]       LAST_FRAME = FC_W'(BLINK_FRAMES - 1);
  localparam logic [N_PANEL*4-1:0]  ALL_BLANK  = {N_PANEL{GLYPH_BLANK}};

  scan_state_t              state_q, state_d;
  logic [2:0]               row_cnt_q, row_cnt_d;
  logic [N_PANEL*4-1:0]     active_q, active_d;
  logic [N_PANEL*4-1:0]     shadow_q, shadow_d;
  logic                     pending_q, pending_d;
  logic [FC_W-1:0]          frame_cnt_q, frame_cnt_d;
  logic                     phase_q, phase_d;
  logic [ROWS-1:0]          dot_row_q, dot_row_d;
  logic [N_PANEL*8-1:0]     dot_col_q, dot_col_d;
  logic                     frame_start_q, frame_start_d;

  logic [N_PANEL*8-1:0]     font_bits;
  logic                     scan_act;
  logic                     row_wrap;
  logic                     commit;
  logic                     accept;

  for (genvar p = 0; p < N_PANEL; p++) begin : g_font
    dot_matrix_font u_font (
      .glyph (active_q[4*p +: 4]),
      .row   (row_cnt_q),
      .bits  (font_bits[8*p +: 8])
    );
  end

  always_comb begin
    state_d       = blank ? BLANK : SCAN;
    // blank takes effect on the same edge that samples it, so that edge is already dark.
    scan_act      = (state_q == SCAN) && !blank;
    row_wrap      = scan_act && (row_cnt_q == LAST_ROW);
    // Committing only at the last row keeps every displayed frame from a single glyph set;
    // while blanked nothing is visible, so the commit need not wait.
    commit        = pending_q && (row_wrap || (state_q == BLANK));
    accept        = load_valid && !pending_q;

    row_cnt_d     = 3'd0;
    dot_row_d     = '1;
    dot_col_d     = '0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    phase_d       = phase_q;

    if (scan_act) begin
      row_cnt_d     = row_wrap ? 3'd0 : row_cnt_q + 3'd1;
      frame_start_d = (row_cnt_q == 3'd0);
      for (int i = 0; i < ROWS; i++) begin
        dot_row_d[ROWS-1-i] = (row_cnt_q != 3'(i));
      end
      for (int p = 0; p < N_PANEL; p++) begin
        dot_col_d[8*p +: 8] = (phase_q && blink_en[p]) ? 8'h00 : font_bits[8*p +: 8];
      end
    end

    if (row_wrap) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Commit reads the pre-edge shadow, so a same-edge accept lands as the next pending load.
    active_d  = commit ? shadow_q : active_q;
    pending_d = pending_q && !commit;
    shadow_d  = shadow_q;
    if (accept) begin
      shadow_d  = glyph_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      state_q       <= BLANK;
      row_cnt_q     <= 3'd0;
      active_q      <= ALL_BLANK;
      shadow_q      <= ALL_BLANK;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      phase_q       <= 1'b0;
      dot_row_q     <= '1;
      dot_col_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      phase_q       <= phase_d;
      dot_row_q     <= dot_row_d;
      dot_col_q     <= dot_col_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign load_ready  = !pending_q;
  assign dot_row     = dot_row_q;
  assign dot_col     = dot_col_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Purpose: self-checking bench for dot_matrix_scan (2 panels, 8 rows, 2-frame blink half-period).
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: the reference model tracks pending/load_ready and accepts loads only when free.
module tb_dot_matrix_scan;

  localparam int NP = 2;
  localparam int NR = 8;

  logic            clk_div = 1'b0;
  logic            reset;
  logic [NP*4-1:0] glyph_in;
  logic            load_valid;
  logic            load_ready;
  logic [NP-1:0]   blink_en;
  logic            blank;
  logic [NR-1:0]   dot_row;
  logic [NP*8-1:0] dot_col;
  logic            frame_start;

  dot_matrix_scan #(.N_PANEL(NP), .ROWS(NR), .BLINK_FRAMES(2)) dut (
    .clk_div     (clk_div),
    .reset       (reset),
    .glyph_in    (glyph_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .blink_en    (blink_en),
    .blank       (blank),
    .dot_row     (dot_row),
    .dot_col     (dot_col),
    .frame_start (frame_start)
  );

  always #5 clk_div = ~clk_div;

  typedef struct packed {
    logic [NR-1:0]   row;
    logic [NP*8-1:0] col;
    logic            fs;
    logic            rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (m_blank_st: 1 = BLANK state).
  logic            m_blank_st;
  int              m_row;
  logic [NP*4-1:0] m_active, m_shadow;
  logic            m_pending;
  int              m_fc;
  logic            m_phase;

  function automatic logic [7:0] font(input logic [3:0] g, input int r);
    logic [63:0] f;
    case (g)
      4'd0:  f = 64'h3C666E7666663C00;
      4'd1:  f = 64'h1838181818187E00;
      4'd2:  f = 64'h3C66060C30607E00;
      4'd3:  f = 64'h3C66061C06663C00;
      4'd4:  f = 64'h0C1C3C6C7E0C0C00;
      4'd5:  f = 64'h7E607C0606663C00;
      4'd6:  f = 64'h3C607C6666663C00;
      4'd7:  f = 64'h7E060C1830303000;
      4'd8:  f = 64'h3C66663C66663C00;
      4'd9:  f = 64'h3C66663E060C3800;
      4'd10: f = 64'h00003E66663E0606;
      4'd11: f = 64'h00003C063E663E00;
      4'd12: f = 64'h000103068CD87020;
      4'd13: f = 64'hC3663C18183C66C3;
      default: f = 64'h0;
    endcase
    return f[63-8*r -: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_blank_st = 1'b1;
    m_row      = 0;
    m_active   = 8'hEE;
    m_shadow   = 8'hEE;
    m_pending  = 1'b0;
    m_fc       = 0;
    m_phase    = 1'b0;
  endtask

  // One clock: predict outputs from current inputs/model state, queue, clock, pop and compare.
  task automatic step();
    exp_t e, g;
    logic scan, wrap, commit, accept;
    scan   = !m_blank_st && !blank;
    wrap   = scan && (m_row == NR-1);
    commit = m_pending && (wrap || m_blank_st);
    accept = load_valid && !m_pending;
    e.row  = scan ? ~(8'h80 >> m_row) : 8'hFF;
    e.col  = '0;
    if (scan)
      for (int p = 0; p < NP; p++)
        e.col[8*p +: 8] = (m_phase && blink_en[p]) ? 8'h00 : font(m_active[4*p +: 4], m_row);
    e.fs = scan && (m_row == 0);
    if (commit) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (accept) begin
      m_shadow  = glyph_in;
      m_pending = 1'b1;
    end
    if (wrap) begin
      if (m_fc == 1) begin
        m_fc    = 0;
        m_phase = !m_phase;
      end else begin
        m_fc = m_fc + 1;
      end
    end
    m_row      = scan ? ((m_row == NR-1) ? 0 : m_row + 1) : 0;
    m_blank_st = blank;
    e.rdy      = !m_pending;
    exp_q.push_back(e);

    @(posedge clk_div);
    #1;
    e = exp_q.pop_front();
    g = '{row: dot_row, col: dot_col, fs: frame_start, rdy: load_ready};
    chk("dot_row",     32'(g.row), 32'(e.row));
    chk("dot_col",     32'(g.col), 32'(e.col));
    chk("frame_start", 32'(g.fs),  32'(e.fs));
    chk("load_ready",  32'(g.rdy), 32'(e.rdy));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge will process row r in SCAN (bounded).
  task automatic goto_row(input int r);
    for (int k = 0; k < 4*NR && !(!m_blank_st && m_row == r); k++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, 32'(dot_row),     32'hFF);
    chk({tag, "_col"}, 32'(dot_col),     32'h0);
    chk({tag, "_fs"},  32'(frame_start), 32'h0);
    chk({tag, "_rdy"}, 32'(load_ready),  32'h1);
  endtask

  initial begin
    reset      = 1'b0;
    glyph_in   = '0;
    load_valid = 1'b0;
    blink_en   = '0;
    blank      = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("reset");
    @(negedge clk_div);
    reset = 1'b1;

    // Idle scan: blank glyphs, rows walk 0x7F..0xFE, frame_start every 8.
    steps(1 + 2*NR);

    // Load at row 3; rows 4-7 keep old glyphs, 'a'/'1' from next frame.
    goto_row(3);
    glyph_in   = 8'h1B;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    steps(2*NR);

    // Continuous load_valid with changing values: one accept per frame.
    load_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      glyph_in = 8'($urandom_range(0, 13)) | (8'($urandom_range(0, 13)) << 4);
      step();
    end
    load_valid = 1'b0;
    steps(NR);

    // Blink on panel 0 across eight frames.
    glyph_in   = 8'hC8;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    blink_en   = 2'b01;
    steps(8*NR);
    blink_en   = 2'b00;

    // Blank at row 5 with a load arriving during blank (commits immediately).
    goto_row(5);
    blank = 1'b1;
    step();
    glyph_in   = 8'hD0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    steps(2);
    blank = 1'b0;
    steps(NR + 3);

    // Reset at row 6 with a pending load: pending glyphs never shown.
    goto_row(2);
    glyph_in   = 8'h9A;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    goto_row(6);
    chk("pending_before_reset", 32'(load_ready), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    model_reset();
    @(negedge clk_div);
    reset = 1'b1;
    steps(2*NR + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
